// File: rtl/mux4_arb_pkg.sv
// Shared types and arbitration helper for mux4_arbiter.
// Option MUX4_ARB_RR_EN selects round-robin, otherwise fixed priority.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE,
    XFER
  } arb_state_t;

  typedef struct packed {
    logic             vld;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set bit of req scanning upward from last+1, wrapping.
  function automatic pick_t rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [SEL_W-1:0]   last
  );
    pick_t            p;
    logic [SEL_W-1:0] i;
    p = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      i = last + SEL_W'(k);
      if (!p.vld && req[i]) begin
        p.vld = 1'b1;
        p.idx = i;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux4_arbiter_mux4.sv
// Four-input single-bit data mux shared by the arbiter.
// Purely combinational; z follows sel and the data inputs.
module mux4
  import mux4_arb_pkg::*;
(
  input  logic             d0,
  input  logic             d1,
  input  logic             d2,
  input  logic             d3,
  input  logic [SEL_W-1:0] sel,
  output logic             z
);

  always_comb begin
    z = d0;
    unique case (sel)
      2'd0: z = d0;
      2'd1: z = d1;
      2'd2: z = d2;
      2'd3: z = d3;
    endcase
  end

endmodule

// File: rtl/mux4_arbiter.sv
// Burst-capped scheduler sharing one mux4 among four requesters.
// Define MUX4_ARB_RR_EN for round-robin; default is fixed priority.
module mux4_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] d,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               out_data,
  output logic               out_valid,
  output logic               busy
);

  localparam int BW = $clog2(BURST_LEN + 1);

  arb_state_t       state;
  logic [SEL_W-1:0] owner;
  logic [BW-1:0]    beats;
  pick_t            pick;
  logic             beat;
  logic             done;

`ifdef MUX4_ARB_RR_EN
  logic [SEL_W-1:0] last;
  assign pick = rr_pick(req, last);
`else
  assign pick = rr_pick(req, SEL_W'(NUM_REQ - 1));
`endif

  assign sel       = owner;
  assign busy      = (state == XFER);
  assign out_valid = busy && req[owner];
  assign beat      = out_valid && out_ready;
  assign done      = beat && (beats == BW'(BURST_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      beats <= '0;
`ifdef MUX4_ARB_RR_EN
      last  <= SEL_W'(NUM_REQ - 1);
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (pick.vld) begin
            owner <= pick.idx;
            grant <= NUM_REQ'(1) << pick.idx;
            beats <= '0;
            state <= XFER;
          end
        end
        XFER: begin
          // withdrawal and final beat both end the grant
          if (!req[owner] || done) begin
`ifdef MUX4_ARB_RR_EN
            last  <= owner;
`endif
            grant <= '0;
            state <= IDLE;
          end else if (beat) begin
            beats <= beats + BW'(1);
          end
        end
      endcase
    end
  end

  mux4 u_mux (
    .d0  (d[0]),
    .d1  (d[1]),
    .d2  (d[2]),
    .d3  (d[3]),
    .sel (sel),
    .z   (out_data)
  );

endmodule

// File: tb/tb_mux4_arbiter.sv
// Randomized and directed bench for mux4_arbiter.
// Reference model tracks grants as plain integers.
module tb_mux4_arbiter;

  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d;
  logic       out_ready;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       out_data;
  logic       out_valid;
  logic       busy;

  mux4_arbiter #(.BURST_LEN(BL)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d         (d),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model
  bit m_busy  = 0;
  int m_owner = 0;
  int m_sel   = 0;
  int m_beats = 0;
  int m_last  = 3;

  function automatic int pick_winner(input logic [3:0] r, input int lst);
`ifdef MUX4_ARB_RR_EN
    for (int k = 1; k <= 4; k++)
      if (r[(lst + k) % 4]) return (lst + k) % 4;
`else
    for (int k = 0; k < 4; k++)
      if (r[k]) return k;
`endif
    return -1;
  endfunction

  task automatic m_step();
    int w;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_sel = 0; m_beats = 0; m_last = 3;
    end else if (!m_busy) begin
      w = pick_winner(req, m_last);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_sel = w; m_beats = 0;
      end
    end else if (!req[m_owner]) begin
      m_busy = 0; m_last = m_owner;
    end else if (out_ready) begin
      m_beats++;
      if (m_beats == BL) begin
        m_busy = 0; m_last = m_owner;
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] eg;
    eg = m_busy ? 4'(1 << m_owner) : 4'h0;
    chk("grant", 32'(grant), 32'(eg));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("out_valid", 32'(out_valid), 32'(m_busy && req[m_owner]));
    chk("out_data", 32'(out_data), 32'(d[m_sel]));
  endtask

  // observed grant history
  int obs_g[$];
  int obs_b[$];
  logic [3:0] prev_g = 4'h0;

  task automatic observe();
    if (grant != 4'h0 && prev_g == 4'h0) begin
      for (int i = 0; i < 4; i++)
        if (grant[i]) obs_g.push_back(i);
      obs_b.push_back(0);
    end
    if (grant != 4'h0 && out_valid && out_ready && obs_b.size() > 0)
      obs_b[obs_b.size() - 1]++;
    prev_g = grant;
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] dd,
                       input logic rdy, input logic rs);
    @(negedge clk);
    req = r; d = dd; out_ready = rdy; rst = rs;
    #1;
    check_outputs();
    observe();
    @(posedge clk);
    m_step();
  endtask

  task automatic do_reset();
    cycle(4'h0, 4'($urandom), 1'b1, 1'b1);
    obs_g.delete();
    obs_b.delete();
  endtask

  int e_order[5];

  initial begin
    req = 4'h0; d = 4'h0; out_ready = 1'b1; rst = 1'b1;
    @(posedge clk);
    m_step();
    do_reset();

    // sole requester 0: burst, turnaround, regrant
    for (int i = 0; i < 12; i++) cycle(4'b0001, 4'($urandom), 1'b1, 1'b0);
    chk("s1_ngrants", 32'(obs_g.size() >= 2), 1);
    if (obs_g.size() >= 2) begin
      chk("s1_g0", 32'(obs_g[0]), 0);
      chk("s1_g1", 32'(obs_g[1]), 0);
      chk("s1_beats", 32'(obs_b[0]), BL);
    end

    // all requesting
    do_reset();
    for (int i = 0; i < 28; i++) cycle(4'b1111, 4'($urandom), 1'b1, 1'b0);
`ifdef MUX4_ARB_RR_EN
    e_order = '{0, 1, 2, 3, 0};
`else
    e_order = '{0, 0, 0, 0, 0};
`endif
    chk("s2_ngrants", 32'(obs_g.size() >= 5), 1);
    if (obs_g.size() >= 5)
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("s2_order%0d", i), 32'(obs_g[i]), 32'(e_order[i]));
        chk($sformatf("s2_beats%0d", i), 32'(obs_b[i]), BL);
      end

    // owner 2 withdraws after two beats
    do_reset();
    for (int i = 0; i < 3; i++) cycle(4'b0100, 4'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(4'b1011, 4'($urandom), 1'b1, 1'b0);
    chk("s3_ngrants", 32'(obs_g.size() >= 2), 1);
    if (obs_g.size() >= 2) begin
      chk("s3_g0", 32'(obs_g[0]), 2);
      chk("s3_beats", 32'(obs_b[0]), 2);
`ifdef MUX4_ARB_RR_EN
      chk("s3_g1", 32'(obs_g[1]), 3);
`else
      chk("s3_g1", 32'(obs_g[1]), 0);
`endif
    end

    // sink stall mid-burst
    do_reset();
    for (int i = 0; i < 3; i++) cycle(4'b0001, 4'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(4'b0001, 4'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b0001, 4'($urandom), 1'b1, 1'b0);
    chk("s4_busy_end", 32'(busy), 0);
    chk("s4_ngrants", 32'(obs_g.size()), 1);
    if (obs_b.size() >= 1) chk("s4_beats", 32'(obs_b[0]), BL);

    // reset during beat 2 of owner 1
    do_reset();
    for (int i = 0; i < 2; i++) cycle(4'b0010, 4'($urandom), 1'b1, 1'b0);
    cycle(4'b0010, 4'($urandom), 1'b1, 1'b1);
    obs_g.delete();
    obs_b.delete();
    cycle(4'b0011, 4'($urandom), 1'b1, 1'b0);
    chk("s5_grant_rst", 32'(grant), 0);
    chk("s5_valid_rst", 32'(out_valid), 0);
    for (int i = 0; i < 2; i++) cycle(4'b0011, 4'($urandom), 1'b1, 1'b0);
    chk("s5_ngrants", 32'(obs_g.size() >= 1), 1);
    if (obs_g.size() >= 1) chk("s5_first", 32'(obs_g[0]), 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] r;
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 9) < 7);
      cycle(r, 4'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 59) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
